// File: rtl/mx_vector_loader_if.sv
// Beat-in / vector-out handshake bundle for the MX vector loader.
// slave is the loader's view; master is the producer/consumer side.
interface mx_vector_loader_if #(
  parameter int BEAT_W = 32,
  parameter int VEC_W  = 264
);
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_last;
  logic [2:0]        in_format;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_vector;
  logic [2:0]        out_format;
  logic              err;

  modport master (
    output in_valid, in_data, in_last, in_format, out_ready,
    input  in_ready, out_valid, out_vector, out_format, err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_format, out_ready,
    output in_ready, out_valid, out_vector, out_format, err
  );
endinterface

// File: rtl/mx_vector_loader.sv
// Assembles a scale beat plus 4/6/8 payload beats into one 264-bit MX vector
// with format tag; flags framing and illegal-format errors with a 1-cycle err pulse.
//
// state | meaning
// IDLE  | waiting for a scale beat (in_ready=1)
// LOAD  | collecting payload beats, cnt = index of next payload beat
// FULL  | vector complete, out_valid=1, input stalled until output transfer
module mx_vector_loader #(
  parameter int BEAT_W = 32,
  parameter int VEC_W  = 264
) (
  input logic              clk,
  input logic              rst,
  mx_vector_loader_if.slave bus
);
  localparam int ELEM_W = VEC_W - 8;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        scale_q;
  logic [2:0]        fmt_q;
  logic [ELEM_W-1:0] elem_q;
  logic              err_q, err_d;
  logic              start, wr_beat;
  logic              in_fire, fmt_ok, final_beat;
  logic [3:0]        n_pay;
  logic [2:0]        slot;

  assign in_fire    = bus.in_valid && bus.in_ready;
  assign fmt_ok     = (bus.in_format <= 3'd5);
  assign final_beat = (cnt_q == n_pay);
  // cnt runs 1..8 in LOAD; slot is its zero-based beat position (8 wraps to 7)
  assign slot       = cnt_q[2:0] - 3'd1;

  always_comb begin
    case (fmt_q)
      3'd2, 3'd3: n_pay = 4'd6;
      3'd4:       n_pay = 4'd4;
      default:    n_pay = 4'd8;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    start   = 1'b0;
    wr_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (!fmt_ok || bus.in_last) begin
            err_d = 1'b1;
          end else begin
            start   = 1'b1;
            cnt_d   = 4'd1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_fire) begin
          wr_beat = 1'b1;
          // in_last must coincide exactly with the last payload beat
          if (bus.in_last != final_beat) begin
            err_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else if (bus.in_last) begin
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      scale_q <= 8'd0;
      fmt_q   <= 3'd0;
      elem_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (start) begin
        scale_q <= bus.in_data[7:0];
        fmt_q   <= bus.in_format;
        elem_q  <= '0;
      end else if (wr_beat) begin
        elem_q[{slot, 5'b0} +: BEAT_W] <= bus.in_data;
      end
    end
  end

  always_comb begin
    bus.in_ready   = (state_q != FULL);
    bus.out_valid  = (state_q == FULL);
    bus.out_vector = {elem_q, scale_q};
    bus.out_format = fmt_q;
    bus.err        = err_q;
  end
endmodule

// File: tb/tb_mx_vector_loader.sv
// Self-checking bench for mx_vector_loader: table-driven vectors with a
// scoreboard queue, plus hand sequences for latency, backpressure and reset.
module tb_mx_vector_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mx_vector_loader_if bus_if();

  mx_vector_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [7:0]  scale;
    logic [31:0] seed;
    logic [31:0] step;
    int          last_at;
    bit          exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int err_cnt = 0;
  logic err_prev = 1'b0;
  logic [263:0] exp_q[$];
  logic [2:0]   expf_q[$];
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int npay(input logic [2:0] f);
    case (f)
      3'd0, 3'd1, 3'd5: return 8;
      3'd2, 3'd3:       return 6;
      3'd4:             return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] pay(input vec_t v, input int k);
    return v.seed + 32'(k) * v.step;
  endfunction

  function automatic logic [263:0] build(input vec_t v);
    logic [263:0] e;
    e = '0;
    e[7:0] = v.scale;
    for (int k = 1; k <= npay(v.fmt); k++) e[8 + 32*(k-1) +: 32] = pay(v, k);
    return e;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [2:0] f);
    bit ok;
    ok = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = d;
    bus_if.in_last   = l;
    bus_if.in_format = f;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    int nb;
    if (v.fmt > 3'd5)       nb = 1;
    else if (v.last_at >= 0) nb = v.last_at + 1;
    else                     nb = npay(v.fmt) + 1;
    if (!v.exp_err) begin
      exp_q.push_back(build(v));
      expf_q.push_back(v.fmt);
    end
    for (int b = 0; b < nb; b++) begin
      if (b == 0) send_beat({v.seed[23:0] ^ 24'hDEAD5A, v.scale}, (v.last_at == 0), v.fmt);
      else        send_beat(pay(v, b), (b == v.last_at), ~v.fmt);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d vectors pending, required 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      err_prev = 1'b0;
    end else begin
      if (bus_if.err) begin
        err_cnt++;
        if (err_prev) begin
          checks++; errors++;
          $display("FAIL err_width: err high 2 cycles, required 1");
        end
      end
      err_prev = bus_if.err;
      if (bus_if.out_valid && bus_if.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: vector %h, required none", bus_if.out_vector);
        end else begin
          chk("out_vector", bus_if.out_vector, exp_q.pop_front());
          chk("out_format", 264'(bus_if.out_format), 264'(expf_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [263:0] e;
    vec_t v;
    int e0, o0;

    tbl[0]  = '{3'd0, 8'h11, 32'hA5A50001, 32'h01020304, 8,  1'b0};
    tbl[1]  = '{3'd1, 8'h7F, 32'h0BADF00D, 32'h1F3D5B79, 8,  1'b0};
    tbl[2]  = '{3'd3, 8'h42, 32'hFFFFFFFF, 32'h00000000, 6,  1'b0};
    tbl[3]  = '{3'd4, 8'h3C, 32'hFFFFFFFF, 32'h00000000, 4,  1'b0};
    tbl[4]  = '{3'd2, 8'h05, 32'h12345678, 32'h1F3D5B79, 6,  1'b0};
    tbl[5]  = '{3'd5, 8'hFE, 32'hCAFEBABE, 32'h01010101, 8,  1'b0};
    tbl[6]  = '{3'd5, 8'h01, 32'h11111111, 32'h02020202, 4,  1'b1};
    tbl[7]  = '{3'd5, 8'h02, 32'h22222222, 32'h03030303, -1, 1'b1};
    tbl[8]  = '{3'd0, 8'h21, 32'h76543210, 32'h10101010, 8,  1'b0};
    tbl[9]  = '{3'd7, 8'h99, 32'h33333333, 32'h00000001, -1, 1'b1};
    tbl[10] = '{3'd1, 8'h33, 32'h89ABCDEF, 32'h0F0F0F0F, 8,  1'b0};
    tbl[11] = '{3'd1, 8'h44, 32'h44444444, 32'h00000001, 0,  1'b1};
    tbl[12] = '{3'd6, 8'h55, 32'h55555555, 32'h00000001, -1, 1'b1};
    tbl[13] = '{3'd4, 8'h66, 32'h66666666, 32'h00000003, 2,  1'b1};
    tbl[14] = '{3'd4, 8'h77, 32'hDEADBEEF, 32'h13579BDF, 4,  1'b0};

    rst = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.in_last = 1'b0;
    bus_if.in_format = 3'd0; bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", 264'(bus_if.out_valid), 264'(0));
    chk("rst_out_vector", bus_if.out_vector, '0);
    chk("rst_out_format", 264'(bus_if.out_format), 264'(0));
    chk("rst_err", 264'(bus_if.err), 264'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 264'(bus_if.in_ready), 264'(1));

    // E4M3 with element i = i, out_valid one cycle after the final beat
    e = '0;
    e[7:0] = 8'h7F;
    for (int i = 0; i < 32; i++) e[8 + 8*i +: 8] = 8'(i);
    exp_q.push_back(e); expf_q.push_back(3'd1);
    send_beat(32'h0000007F, 1'b0, 3'd1);
    for (int k = 1; k <= 7; k++) send_beat(32'h03020100 + 32'(k-1) * 32'h04040404, 1'b0, 3'd1);
    chk("lat_before_valid", 264'(bus_if.out_valid), 264'(0));
    send_beat(32'h1F1E1D1C, 1'b1, 3'd1);
    chk("lat_out_valid", 264'(bus_if.out_valid), 264'(1));
    chk("lat_in_ready", 264'(bus_if.in_ready), 264'(0));
    wait_drain();

    for (int i = 0; i < 15; i++) begin
      e0 = err_cnt; o0 = out_cnt;
      send_vec(tbl[i]);
      if (!tbl[i].exp_err) wait_drain();
      repeat (3) @(posedge clk); #1;
      chk($sformatf("tbl%0d_err_count", i), 264'(err_cnt - e0), 264'(tbl[i].exp_err ? 1 : 0));
      chk($sformatf("tbl%0d_out_count", i), 264'(out_cnt - o0), 264'(tbl[i].exp_err ? 0 : 1));
    end

    // backpressure: INT8 vector held 10 cycles
    bus_if.out_ready = 1'b0;
    v = '{3'd5, 8'hC3, 32'h12345678, 32'h0A0B0C0D, 8, 1'b0};
    e = build(v);
    send_vec(v);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 264'(bus_if.in_ready), 264'(0));
      chk("bp_out_valid", 264'(bus_if.out_valid), 264'(1));
      chk("bp_out_vector", bus_if.out_vector, e);
    end
    bus_if.out_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle_refill", 264'(bus_if.in_ready), 264'(0));
    @(posedge clk); #1;
    chk("bp_in_ready_after", 264'(bus_if.in_ready), 264'(1));
    chk("bp_out_valid_after", 264'(bus_if.out_valid), 264'(0));
    wait_drain();

    // async reset mid-LOAD, after 4 beats of an FP8 vector
    v = '{3'd0, 8'hAB, 32'h0F0E0D0C, 32'h11111111, 8, 1'b0};
    send_beat({24'h0, v.scale}, 1'b0, v.fmt);
    for (int k = 1; k <= 3; k++) send_beat(pay(v, k), 1'b0, v.fmt);
    #2 rst = 1'b1;
    #1;
    chk("rst_load_out_valid", 264'(bus_if.out_valid), 264'(0));
    chk("rst_load_out_vector", bus_if.out_vector, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_load_in_ready", 264'(bus_if.in_ready), 264'(1));

    // async reset in FULL with out_valid high
    bus_if.out_ready = 1'b0;
    send_vec('{3'd2, 8'hBC, 32'hFEDCBA98, 32'h01234567, 6, 1'b0});
    chk("rst_full_pre_valid", 264'(bus_if.out_valid), 264'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_full_out_valid", 264'(bus_if.out_valid), 264'(0));
    chk("rst_full_out_vector", bus_if.out_vector, '0);
    chk("rst_full_out_format", 264'(bus_if.out_format), 264'(0));
    exp_q.delete(); expf_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_full_in_ready", 264'(bus_if.in_ready), 264'(1));
    o0 = out_cnt;
    send_vec('{3'd4, 8'h5D, 32'h0BADCAFE, 32'h00010001, 4, 1'b0});
    wait_drain();
    chk("fresh_out_count", 264'(out_cnt - o0), 264'(1));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mx_vector_loader.md
Name: mx_vector_loader

Overview:
- Serial-to-parallel assembler that sits directly upstream of the MX ALU datapath.
- Accepts a 32-bit beat stream from the memory/stream interface and builds one complete MX vector: 8-bit scale plus 32 elements in FP8 E5M2, FP8 E4M3, FP6 E3M2, FP6 E2M3, FP4 E2M1 or INT8.
- Presents the vector as one LARGEST_VECTOR_SIZE-wide (264-bit) word with a format tag, using valid/ready.
- Checks framing and format, and flags errors.

Parameters:
- BEAT_W, 32, input beat width; only the value 32 is supported.
- VEC_W, 264, output vector width; equals LARGEST_VECTOR_SIZE from mx_format_pkg.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  loader can accept a beat.
- in_data  input  32  beat payload.
- in_last  input  1  marks the final beat of a vector.
- in_format  input  3  format code. Sampled only on the scale beat. 0=E5M2, 1=E4M3, 2=E3M2, 3=E2M3, 4=E2M1, 5=INT8; 6 and 7 are illegal.
- out_valid  output  1  assembled vector available.
- out_ready  input  1  consumer accepts the vector.
- out_vector  output  264  [7:0] = scale. Element i occupies [8+EW*i +: EW], where EW is 8, 6 or 4 for the format. Bits above 8+32*EW are zero.
- out_format  output  3  format code latched with the vector.
- err  output  1  one-cycle pulse on a framing or format error.

Behaviour:
- Beat transfer occurs when in_valid and in_ready are both high. Output transfer occurs when out_valid and out_ready are both high.
- Beat layout:
  - Beat 0 is the scale beat: in_data[7:0] = scale; in_data[31:8] ignored.
  - Beats 1..P carry element data, packed LSB-first and contiguously. Payload beat k supplies element-region bits [32(k-1) +: 32].
  - P is 8 for FP8/INT8, 6 for FP6 and 4 for FP4.
  - Total beats per vector N = P+1, i.e. 9, 7 or 5.
- FSM states: IDLE, LOAD, FULL.
  - IDLE: in_ready=1.
    - Legal format on a beat transfer: latch scale and format, clear the element buffer, set beat counter to 1, go to LOAD.
    - Illegal format (6/7): consume the beat, pulse err the next cycle, stay in IDLE.
    - in_last=1 on the scale beat with a legal format: framing error; pulse err, stay in IDLE.
  - LOAD: in_ready=1. Each transfer writes its 32 bits at element-region offset 32*(counter-1), then increments the counter.
    - Counter reaches N-1 on a beat with in_last=1: go to FULL.
    - in_last=1 before the final beat, or in_last=0 on the final beat: discard the partial vector, pulse err, go to IDLE.
    - A beat arriving after an error is treated as a new scale beat.
  - FULL: in_ready=0, out_valid=1. out_vector and out_format stay stable until the output transfer, then go to IDLE.
    - No same-cycle refill: in_ready rises the cycle after the transfer.
- Latency: out_valid asserts the cycle after the final beat transfer. Back-to-back throughput is one vector per N+1 cycles.
- Zero-fill: element-region bits not written for the current format are always 0. Verification compares the full 264 bits.
- in_format is ignored on payload beats.
- Reset (asynchronous, any state, including mid-LOAD or FULL with out_valid high):
  - state=IDLE, counter=0, out_valid=0, out_vector=0, out_format=0, err=0.
  - in_ready=1 from the first clock edge after reset deasserts.
- err is registered; it never stays asserted for more than one cycle per error event.
- Beat counter: 4 bits; it never wraps within a legal vector.

Test Plan:
1. FP8 E4M3: format=1, scale beat 0x000000_7F, then 8 beats 0x03020100..0x1F1E1D1C, last on beat 9 -> out_vector[7:0]=0x7F, element i=i, out_format=1, out_valid exactly 1 cycle after beat 9.
2. FP6 E2M3: format=3, 7 beats, payload all 0xFFFFFFFF -> bits[199:8] all ones, bits[263:200]=0, no err. FP4: format=4, 5 beats -> bits[263:136]=0.
3. Backpressure: hold out_ready=0 for 10 cycles after a complete INT8 vector -> in_ready=0, out_vector stable; out_ready=1 -> transfer, in_ready=1 the next cycle.
4. Framing: INT8 vector with in_last on beat 5 -> err pulse, no out_valid; in_last missing on beat 9 -> err pulse, and the next beat is parsed as a scale beat.
5. Illegal format 7 on the scale beat -> err pulse for 1 cycle, state stays IDLE, a following legal vector assembles correctly.
6. Assert rst asynchronously mid-LOAD (beat 4 of an FP8 vector) and again in FULL -> out_valid=0, out_vector=0 immediately; a fresh vector after reset is correct with no stale data.
